// File: rtl/pipe_csel_addsub.sv
// Pipelined carry-select adder/subtractor; each stage resolves WIDTH/BLK/STAGES blocks.
// Latency: STAGES cycles from acceptance to out_valid; one beat per cycle.
// Backpressure: whole pipe advances only when the output slot is empty or being drained;
//               in_ready = !out_valid || out_ready, and every stage holds otherwise.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; op (0 = a+b, 1 = a-b), a, b
//   out_valid/out_ready  result handshake; s (mod 2^WIDTH), co (1 = no borrow on
//                        subtract), ovf (signed overflow), zero (s == 0)
//
// Parameter legality: WIDTH % BLK == 0, (WIDTH/BLK) % STAGES == 0, STAGES >= 1.
module pipe_csel_addsub #(
    parameter int WIDTH  = 20,
    parameter int BLK    = 4,
    parameter int STAGES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NBLK = WIDTH / BLK;
    localparam int NPS  = NBLK / STAGES;

    // Per-stage state: raw operands and op travel with the beat so later stages
    // can form the effective b for their own blocks; s_q holds the resolved low
    // part of the sum and c_q the carry into the next unresolved block.
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             c_q  [STAGES];
    logic             op_q [STAGES];
    logic             v_q  [STAGES];
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] nx_a  [STAGES];
    logic [WIDTH-1:0] nx_b  [STAGES];
    logic [WIDTH-1:0] nx_s  [STAGES];
    logic             nx_c  [STAGES];
    logic             nx_op [STAGES];
    logic             nx_ovf;
    logic             nx_zero;

    // Working values while walking one stage's blocks.
    logic [WIDTH-1:0] ca, cb, cbe, cs;
    logic             cc, cop;
    logic [BLK:0]     s0, s1;

    logic en;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign co        = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        ca      = '0;
        cb      = '0;
        cbe     = '0;
        cs      = '0;
        cc      = 1'b0;
        cop     = 1'b0;
        s0      = '0;
        s1      = '0;
        nx_ovf  = 1'b0;
        nx_zero = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // Subtract is a + ~b with carry-in 1: the carry-in is just op.
                ca  = a;
                cb  = b;
                cop = op;
                cs  = '0;
                cc  = op;
            end else begin
                ca  = a_q[(k > 0) ? k - 1 : 0];
                cb  = b_q[(k > 0) ? k - 1 : 0];
                cop = op_q[(k > 0) ? k - 1 : 0];
                cs  = s_q[(k > 0) ? k - 1 : 0];
                cc  = c_q[(k > 0) ? k - 1 : 0];
            end
            cbe = cb ^ {WIDTH{cop}};
            for (int j = 0; j < NPS; j++) begin
                // Both carry-in candidates are formed up front; the incoming
                // block carry only drives the final mux.
                s0 = {1'b0, ca[(k*NPS+j)*BLK +: BLK]} + {1'b0, cbe[(k*NPS+j)*BLK +: BLK]};
                s1 = {1'b0, ca[(k*NPS+j)*BLK +: BLK]} + {1'b0, cbe[(k*NPS+j)*BLK +: BLK]}
                     + (BLK+1)'(1);
                cs[(k*NPS+j)*BLK +: BLK] = cc ? s1[BLK-1:0] : s0[BLK-1:0];
                cc = cc ? s1[BLK] : s0[BLK];
            end
            nx_a[k]  = ca;
            nx_b[k]  = cb;
            nx_s[k]  = cs;
            nx_c[k]  = cc;
            nx_op[k] = cop;
            if (k == STAGES - 1) begin
                nx_ovf  = (ca[WIDTH-1] == cbe[WIDTH-1]) && (cs[WIDTH-1] != ca[WIDTH-1]);
                nx_zero = (cs == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                op_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= (k == 0) ? (in_valid && in_ready) : v_q[(k > 0) ? k - 1 : 0];
                a_q[k]  <= nx_a[k];
                b_q[k]  <= nx_b[k];
                s_q[k]  <= nx_s[k];
                c_q[k]  <= nx_c[k];
                op_q[k] <= nx_op[k];
            end
            ovf_q  <= nx_ovf;
            zero_q <= nx_zero;
        end
    end

endmodule

// File: doc/pipe_csel_addsub.md
PIPE_CSEL_ADDSUB -- requirements
Module: pipe_csel_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, operand/result width in bits.
REQ-002 The block SHALL have parameter BLK, default 4, carry-select block width; WIDTH % BLK == 0.
REQ-003 The block SHALL have parameter STAGES, default 5, number of pipeline register stages; (WIDTH/BLK) % STAGES == 0 and STAGES >= 1.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, operand beat present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, block accepts a beat this cycle.
REQ-008 The block SHALL have port op, input, 1 bit, 0 = a+b and 1 = a-b.
REQ-009 The block SHALL have port a, input, WIDTH bits, first operand.
REQ-010 The block SHALL have port b, input, WIDTH bits, second operand.
REQ-011 The block SHALL have port out_valid, output, 1 bit, result beat present.
REQ-012 The block SHALL have port out_ready, input, 1 bit, downstream accepts the result.
REQ-013 The block SHALL have port s, output, WIDTH bits, result modulo 2^WIDTH.
REQ-014 The block SHALL have port co, output, 1 bit, carry out; for subtract, 1 = no borrow.
REQ-015 The block SHALL have port ovf, output, 1 bit, two's-complement signed overflow.
REQ-016 The block SHALL have port zero, output, 1 bit, set when s == 0.

Function
REQ-017 The block SHALL compute subtract as a + ~b with carry-in 1 into block 0, and add as a + b with carry-in 0; no separate increment of b.
REQ-018 The block SHALL split the operands into NBLK = WIDTH/BLK blocks; blocks 1..NBLK-1 each SHALL compute both the ci=0 and ci=1 sums and select by the incoming block carry.
REQ-019 Pipeline stage k (0..STAGES-1) SHALL resolve blocks k*NPS .. (k+1)*NPS-1, where NPS = NBLK/STAGES, and register the partial sum, the carry, and the still-unprocessed operand bits plus op.
REQ-020 The global advance enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
REQ-021 A beat SHALL be accepted when in_valid && in_ready; when en = 1, every stage valid bit SHALL shift forward, and stage 0 SHALL load in_valid && in_ready.
REQ-022 When en = 0, all stage registers, including data and valid bits, SHALL hold.
REQ-023 With out_ready held at 1, a beat accepted in cycle t SHALL show out_valid = 1 with its result in cycle t+STAGES; throughput SHALL be 1 beat per cycle.
REQ-024 Bubbles (in_valid = 0) SHALL propagate as invalid stages; results SHALL leave in acceptance order, with no reordering, loss, or duplication.
REQ-025 ovf SHALL be 1 iff the sign of a equals the sign of the effective b (b for add, ~b for subtract) and the sign of s differs from it.
REQ-026 s, co, ovf, and zero SHALL be registered outputs of the last stage, stable while out_valid && !out_ready.
REQ-027 Data registers SHALL be don't-care when the matching valid bit is 0; only out_valid is guaranteed meaningful.

Reset
REQ-028 When rst = 1 at a clock edge, all stage valid bits and out_valid SHALL go to 0, and s, co, ovf, and zero SHALL go to 0.
REQ-029 Reset SHALL take priority over acceptance; a beat presented in the reset cycle SHALL be dropped, and in-flight beats SHALL be discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after reset, since out_valid = 0.

Verification
REQ-031 Default parameters, op=1, a=0x00005, b=0x00003 -> 5 cycles later s=0x00002, co=1, ovf=0, zero=0.
REQ-032 op=1, a=0x00003, b=0x00005 -> s=0xFFFFE, co=0, ovf=0; then op=0, a=0x7FFFF, b=0x00001 -> s=0x80000, co=0, ovf=1.
REQ-033 op=0, a=0xFFFFF, b=0x00001 -> s=0x00000, co=1, zero=1, ovf=0; carry SHALL ripple correctly across all 5 stage boundaries.
REQ-034 Back-to-back stream of 10 beats with out_ready toggling randomly -> every beat emerges once, in order; in_ready == !out_valid || out_ready every cycle; outputs are stable while stalled.
REQ-035 rst asserted for 1 cycle while 3 beats are in flight -> out_valid=0 next cycle, none of the 3 beats ever emerge, and a beat accepted after reset emerges 5 cycles later.
REQ-036 Parameter sweep WIDTH/BLK/STAGES in {(20,4,1),(16,4,2),(32,8,4)} with 10k random a, b, op -> s/co/ovf/zero match a reference model; latency == STAGES.
